pipe_muldiv_seq: RTL
====================

// Module: pipe_muldiv_seq
// PURPOSE
//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the pipelined CPU. Accepts an op from
//  the EXE stage, runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles,
//  and holds the pipeline via stall until done. Drives the HI/LO writeback data and enables
//  into the MEM/WB path.
// PARAMETERS
//  WIDTH  32  operand width; hi/lo are WIDTH each; iteration count = WIDTH
// PORTS
//  clk     in   1      rising-edge clock
//  rst     in   1      asynchronous reset, active-low
//  start   in   1      EXE holds a mul/div op; sampled only in IDLE or DONE
//  op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//  a       in   WIDTH  rs operand (multiplicand / dividend); sampled with start
//  b       in   WIDTH  rt operand (multiplier / divisor); sampled with start
//  cancel  in   1      pipeline flush; aborts any op in progress
//  stall   out  1      freeze PC/IR/DE; combinational
//  busy    out  1      1 in RUN or FIX
//  done    out  1      1-cycle pulse; hi/lo hold the new result
//  hi      out  WIDTH  MULT*: product[2W-1:W]; DIV*: remainder
//  lo      out  WIDTH  MULT*: product[W-1:0];  DIV*: quotient
//  w_hi    out  1      = done; HI write enable
//  w_lo    out  1      = done; LO write enable
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, counter=0, hi=lo=0, busy=done=w_hi=w_lo=0.
//  States: IDLE, RUN, FIX, DONE.
//   IDLE: start & ~cancel -> RUN. Latch op, |a|, |b| (abs only for signed ops), sign
//     flags sa=a[W-1], sb=b[W-1] (signed ops only, else 0), counter=0.
//   RUN: one iteration per cycle, counter++. When counter==WIDTH-1 -> FIX.
//     MUL: if acc_lo[0] then acc_hi += mcand (W+1-bit sum); shift {carry,acc_hi,acc_lo} right 1.
//     DIV: rem = {rem[W-2:0], q[W-1]}; trial = rem - divisor (W+1 bits);
//      if trial >= 0 then rem = trial, q bit 1, else q bit 0; shift q left.
//   FIX: sign correction, then -> DONE.
//     MULT: negate 2W-bit product when sa^sb.
//     DIV: negate quotient when sa^sb; negate remainder when sa.
//     Divisor==0 (any DIV*): hi=original a, lo={WIDTH{1'b1}}; no trap.
//     DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, no trap).
//   DONE: done=w_hi=w_lo=1 for exactly this cycle; hi/lo registers updated on
//     FIX->DONE edge and held until the next DONE.
//     start & ~cancel -> RUN (back-to-back, same latch rules as IDLE); else -> IDLE.
//  Latency: start sampled at edge E0; done high in the cycle after edge E0+WIDTH+1,
//   i.e. WIDTH+2 cycles counting the start cycle as cycle 0 (34 for WIDTH=32).
//  stall = busy | (start & ~cancel & (state==IDLE | state==DONE)). It drops in the
//   DONE cycle unless a new op is accepted, so the EXE instruction advances with done.
//  cancel has priority over start. In RUN/FIX -> IDLE next edge, no done pulse, hi/lo
//   unchanged. In DONE the pulse still completes; no new op is accepted.
//  start while busy is ignored; the EXE stage holds it under stall.
//  Operands are latched at E0, so a/b changes after E0 do not affect the result.
// TESTING
//  1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at cycle 34; hi=0xFFFFFFFE lo=0x00000001;
//    stall high cycles 0..33.
//  2 MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB (-21).
//  3 DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//    DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
//  4 DIVU a=100 b=0 -> hi=0x00000064 lo=0xFFFFFFFF; done at cycle 34.
//  5 Start DIVU 9/4; cancel at cycle 10 -> IDLE at cycle 11, no done, hi/lo keep prior
//    values; start with cancel=1 in IDLE -> not accepted, stall=0.
//  6 Back-to-back: second start held high in the DONE cycle -> second done 34 cycles later.
//    rst low mid-RUN -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/pipe_muldiv_seq.sv
// pipe_muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer that stalls the pipeline until HI/LO are ready
module pipe_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             w_hi,
  output logic             w_lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t             state;
  logic [1:0]         op_r;
  logic               sa, sb;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opnd, acc_hi, acc_lo, a_r;
  logic               sgn_a, sgn_b, accept, div_ok;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [2*WIDTH-1:0] prod;
  assign sgn_a   = ~op[0] & a[WIDTH-1];
  assign sgn_b   = ~op[0] & b[WIDTH-1];
  assign abs_a   = sgn_a ? -a : a;
  assign abs_b   = sgn_b ? -b : b;
  assign accept  = start & ~cancel;
  assign stall   = busy | (accept & (state == IDLE | state == DONE));
  assign w_hi    = done;
  assign w_lo    = done;
  // multiply keeps the product in {acc_hi,acc_lo}; divide keeps remainder in acc_hi, quotient in acc_lo
  assign mul_sum = {1'b0, acc_hi} + {1'b0, opnd & {WIDTH{acc_lo[0]}}};
  assign div_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ok  = div_sh >= {1'b0, opnd};
  assign prod    = (sa ^ sb) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_r   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      cnt    <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      a_r    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= accept ? RUN : IDLE;
          busy  <= accept;
          if (accept) begin
            op_r   <= op;
            sa     <= sgn_a;
            sb     <= sgn_b;
            cnt    <= '0;
            opnd   <= abs_b;
            acc_hi <= '0;
            acc_lo <= abs_a;
            a_r    <= a;
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt    <= cnt + CW'(1);
            state  <= (cnt == CW'(WIDTH - 1)) ? FIX : RUN;
            acc_hi <= op_r[1] ? (div_ok ? div_sh[WIDTH-1:0] - opnd : div_sh[WIDTH-1:0]) : mul_sum[WIDTH:1];
            acc_lo <= op_r[1] ? {acc_lo[WIDTH-2:0], div_ok} : {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          busy  <= 1'b0;
          state <= cancel ? IDLE : DONE;
          if (!cancel) begin
            done <= 1'b1;
            hi   <= !op_r[1] ? prod[2*WIDTH-1:WIDTH] : (opnd == '0) ? a_r : sa ? -acc_hi : acc_hi;
            lo   <= !op_r[1] ? prod[WIDTH-1:0] : (opnd == '0) ? '1 : (sa ^ sb) ? -acc_lo : acc_lo;
          end
        end
      endcase
    end
  end
endmodule
